rv_fetch_unit: RTL
==================

// Module: rv_fetch_unit
// PURPOSE
//  PC register, instruction fetch sequencer and next-PC resolver for the RV32I multi-cycle core.
//  Drives the instruction-memory request, holds the fetched word and its PC steady for the execute stage,
//  then consumes execute's next-PC controls (src, raw immediates, branch condition, exception) to pick the next PC.
// PARAMETERS
//  RESET_PC        32'h0000_0000  PC loaded at reset
//  TIMEOUT_CYCLES  255            fetch watchdog limit (used only with RV_FETCH_TIMEOUT_EN)
// PORTS
//  iwClk                input  1   clock; all state updates on rising edge
//  iwnRst               input  1   synchronous, active-low reset
//  orIMemReq            output 1   fetch request, held high until ack
//  orIMemAddr           output 32  fetch address (== orPc)
//  iwIMemAck            input  1   instruction word valid this cycle
//  iwIMemData           input  32  instruction word
//  orInstr              output 32  latched instruction to execute stage
//  orPc                 output 32  PC of orInstr
//  orInstrValid         output 1   orInstr/orPc valid, execute may proceed
//  iwExecDone           input  1   execute finished; next-PC controls valid this cycle
//  iwNextPcSrc          input  2   NEXT_PC_SRC_{SEQ,JAL,JALR,B}
//  iwNextPcImmediate20  input  20  raw instr[31:12]
//  iwNextPcImmediate12  input  12  JALR: instr[31:20]; B: {instr[31:25],instr[11:7]}
//  iwBranchCond         input  1   ALU compare result bit 0
//  iwBranchInverted     input  1   invert branch condition
//  iwRs1Data            input  32  rs1 value for JALR
//  iwException          input  4   execute exception code
//  orHalted             output 1   core halted (sticky until reset)
//  orHaltCause          output 4   exception code that caused halt
// BEHAVIOUR
//  Reset (iwnRst=0 at edge): state=FETCH, orPc=orIMemAddr=RESET_PC, orIMemReq=0, orInstr=0,
//   orInstrValid=0, orHalted=0, orHaltCause=EXCEPTION_SUCCESS. Reset mid-fetch drops req at that edge.
//  FSM states FETCH, EXEC, HALT:
//   FETCH: orIMemReq=1 (from first cycle after reset release); on edge with iwIMemAck=1 latch
//    iwIMemData->orInstr, go EXEC. Ack in EXEC/HALT ignored. Min latency req->EXEC = 1 cycle.
//   EXEC: orInstrValid=1, orIMemReq=0, orInstr/orPc stable. Wait for iwExecDone; on that edge:
//    - iwException!=EXCEPTION_SUCCESS -> HALT, orHaltCause=iwException, orPc unchanged.
//    - else target misaligned (target[1:0]!=0) -> HALT, orHaltCause=EXCEPTION_MISALIGNED, orPc unchanged.
//    - else orPc<=target, go FETCH.
//   HALT: all requests 0, orInstrValid=0, orHalted=1; exit only via reset.
//  Target (all adds modulo 2^32, wrap silently):
//   SEQ : pc+4
//   JAL : pc+sext21({i20[19],i20[7:0],i20[8],i20[18:9],1'b0})
//   JALR: (rs1+sext32(i12)) & ~32'h1
//   B   : taken=iwBranchCond^iwBranchInverted; taken ? pc+sext13({i12[11],i12[0],i12[10:5],i12[4:1],1'b0}) : pc+4
//  Exception precedence: iwException over misaligned. Best case 2 cycles/instr (FETCH+EXEC).
// CONFIGURATION
//  RV_FETCH_TIMEOUT_EN defined: 8-bit counter clears on FETCH entry and increments each FETCH cycle
//   without ack; when it reaches TIMEOUT_CYCLES with no ack -> HALT, orHaltCause=EXCEPTION_FETCH_TIMEOUT.
//   Ack in that same cycle wins (no timeout).
//  Undefined: no counter; FETCH waits indefinitely.
// STRUCTURE
//  macros/control.v: EXCEPTION_MISALIGNED, EXCEPTION_FETCH_TIMEOUT; macros/control_rv.v: existing
//   NEXT_PC_SRC_* plus FETCH_STATE_{FETCH,EXEC,HALT} (2-bit) encodings.
//  Sub-module rv_next_pc: purely combinational target computation + misalign flag; FSM/regs in top.
// TESTING
//  Reset, RESET_PC=0x100, ack 2 cycles after req -> orIMemAddr=0x100, orInstrValid high cycle after ack.
//  SEQ exec done at pc=0x100 -> next fetch addr 0x104; pc=0xFFFFFFFC SEQ -> wraps to 0x0.
//  JAL instr 0x0080006F (+8) at 0x200 -> 0x208; JALR rs1=0x301, i12=0x004 -> 0x304 (bit0 cleared).
//  BNE (cond=1, inv=1) i12 encoding -16 at 0x400 -> 0x404; cond=0 inv=1 -> 0x3F0.
//  iwException=EXCEPTION_ILLEGAL_INSTR with JAL target 0x202 -> halt cause ILLEGAL, orPc stays, req stays 0.
//  RV_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, never ack -> halt after 4 FETCH cycles; reset recovers to RESET_PC.

Source files
------------

// File: rtl/rv_fetch_unit_pkg.sv
// Shared encodings for the RV32I fetch unit: next-PC sources, FSM states and exception codes.
package rv_fetch_unit_pkg;

    localparam logic [1:0] NEXT_PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] NEXT_PC_SRC_JAL  = 2'd1;
    localparam logic [1:0] NEXT_PC_SRC_JALR = 2'd2;
    localparam logic [1:0] NEXT_PC_SRC_B    = 2'd3;

    typedef enum logic [1:0] {
        FETCH_STATE_FETCH = 2'd0,
        FETCH_STATE_EXEC  = 2'd1,
        FETCH_STATE_HALT  = 2'd2
    } fetch_state_e;

    localparam logic [3:0] EXCEPTION_SUCCESS       = 4'h0;
    localparam logic [3:0] EXCEPTION_ILLEGAL_INSTR = 4'h1;
    localparam logic [3:0] EXCEPTION_MISALIGNED    = 4'h2;
    localparam logic [3:0] EXCEPTION_FETCH_TIMEOUT = 4'h3;

endpackage

// File: rtl/rv_fetch_unit_next_pc.sv
// Combinational next-PC target computation and misalignment flag.
module rv_next_pc
    import rv_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  src_i,
    input  logic [19:0] imm20_i,
    input  logic [11:0] imm12_i,
    input  logic        cond_i,
    input  logic        inv_i,
    input  logic [31:0] rs1_i,
    output logic [31:0] target_o,
    output logic        misaligned_o
);

    logic [31:0] jal_off;
    logic [31:0] b_off;
    logic [31:0] jalr_sum;

    always_comb begin
        // Raw immediate fields are unscrambled back into J- and B-type offsets here.
        jal_off  = {{11{imm20_i[19]}}, imm20_i[19], imm20_i[7:0], imm20_i[8], imm20_i[18:9], 1'b0};
        b_off    = {{19{imm12_i[11]}}, imm12_i[11], imm12_i[0], imm12_i[10:5], imm12_i[4:1], 1'b0};
        jalr_sum = rs1_i + {{20{imm12_i[11]}}, imm12_i};
        target_o = pc_i + 32'd4;
        case (src_i)
            NEXT_PC_SRC_JAL:  target_o = pc_i + jal_off;
            NEXT_PC_SRC_JALR: target_o = jalr_sum & ~32'h1;
            NEXT_PC_SRC_B:    target_o = (cond_i ^ inv_i) ? pc_i + b_off : pc_i + 32'd4;
            default:          target_o = pc_i + 32'd4;
        endcase
        misaligned_o = (target_o[1:0] != 2'b00);
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// PC register and FETCH/EXEC/HALT sequencer for the multi-cycle RV32I core.
// Optional fetch watchdog enabled with RV_FETCH_TIMEOUT_EN.
module rv_fetch_unit
    import rv_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    output logic        orIMemReq,
    output logic [31:0] orIMemAddr,
    input  logic        iwIMemAck,
    input  logic [31:0] iwIMemData,
    output logic [31:0] orInstr,
    output logic [31:0] orPc,
    output logic        orInstrValid,
    input  logic        iwExecDone,
    input  logic [1:0]  iwNextPcSrc,
    input  logic [19:0] iwNextPcImmediate20,
    input  logic [11:0] iwNextPcImmediate12,
    input  logic        iwBranchCond,
    input  logic        iwBranchInverted,
    input  logic [31:0] iwRs1Data,
    input  logic [3:0]  iwException,
    output logic        orHalted,
    output logic [3:0]  orHaltCause
);

    fetch_state_e state_q;
    logic         req_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         valid_q;
    logic         halted_q;
    logic [3:0]   cause_q;
    logic [31:0]  target;
    logic         misaligned;

`ifdef RV_FETCH_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_q;
`endif

    rv_next_pc u_next_pc (
        .pc_i        (pc_q),
        .src_i       (iwNextPcSrc),
        .imm20_i     (iwNextPcImmediate20),
        .imm12_i     (iwNextPcImmediate12),
        .cond_i      (iwBranchCond),
        .inv_i       (iwBranchInverted),
        .rs1_i       (iwRs1Data),
        .target_o    (target),
        .misaligned_o(misaligned)
    );

    always_ff @(posedge iwClk) begin
        if (!iwnRst) begin
            state_q  <= FETCH_STATE_FETCH;
            req_q    <= 1'b0;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cause_q  <= EXCEPTION_SUCCESS;
`ifdef RV_FETCH_TIMEOUT_EN
            tmo_q    <= 8'h0;
`endif
        end else begin
            unique case (state_q)
                FETCH_STATE_FETCH: begin
                    if (req_q && iwIMemAck) begin
                        instr_q <= iwIMemData;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= FETCH_STATE_EXEC;
`ifdef RV_FETCH_TIMEOUT_EN
                    end else if (req_q && tmo_q >= TmoLast) begin
                        req_q    <= 1'b0;
                        halted_q <= 1'b1;
                        cause_q  <= EXCEPTION_FETCH_TIMEOUT;
                        state_q  <= FETCH_STATE_HALT;
                    end else begin
                        req_q <= 1'b1;
                        if (req_q) tmo_q <= tmo_q + 8'd1;
                    end
`else
                    end else begin
                        req_q <= 1'b1;
                    end
`endif
                end
                FETCH_STATE_EXEC: begin
                    if (iwExecDone) begin
                        valid_q <= 1'b0;
                        if (iwException != EXCEPTION_SUCCESS || misaligned) begin
                            halted_q <= 1'b1;
                            cause_q  <= (iwException != EXCEPTION_SUCCESS) ? iwException
                                                                           : EXCEPTION_MISALIGNED;
                            state_q  <= FETCH_STATE_HALT;
                        end else begin
                            pc_q    <= target;
                            req_q   <= 1'b1;
                            state_q <= FETCH_STATE_FETCH;
`ifdef RV_FETCH_TIMEOUT_EN
                            tmo_q   <= 8'h0;
`endif
                        end
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign orIMemReq    = req_q;
    assign orIMemAddr   = pc_q;
    assign orPc         = pc_q;
    assign orInstr      = instr_q;
    assign orInstrValid = valid_q;
    assign orHalted     = halted_q;
    assign orHaltCause  = cause_q;

endmodule
